mp_sysbus_pq: RTL and testbench

//  Parametrised management-bus master for the sodium core. Posted writes are buffered in a DEPTH-entry FIFO so that
//  the pipeline does not stall on writes. Reads drain the queue first, which preserves program order, and stall the

---
 rtl/mp_sysbus_pq.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_mp_sysbus_pq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_sysbus_pq.sv
// Management-bus master: posted writes queue in a FIFO, reads drain the queue first then stall until data returns.
// Latency: write N -> req N+2, read N -> req N+1, rxe R -> wb R+1; backpressure via stall = queue full | read outstanding.

module mp_sysbus_pq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == (PW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_rdy & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module mp_sysbus_pq #(
  parameter int AW      = 13,
  parameter int DEPTH   = 4,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   issue,
  input  logic                   rwn,
  input  logic [1:0]             tag2,
  input  logic                   sel,
  input  logic [AW-1:0]          addr,
  input  logic [31:0]            data,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   wb,
  output logic                   wb32,
  output logic [31:0]            wb_data,
  output logic                   err,
  output logic [AW-1:0]          err_addr,
  output logic                   mgmt_req,
  output logic [31:0]            mgmt_adr,
  input  logic                   mgmt_ack,
  output logic                   mgmt_rwn,
  output logic [1:0]             mgmt_wen,
  output logic [31:0]            mgmt_txd,
  input  logic                   mgmt_rxe,
  input  logic [31:0]            mgmt_rxd
);
  localparam logic [1:0] TAG_W = 2'b00;
  localparam logic [1:0] TAG_H = 2'b01;
  localparam logic [1:0] TAG_L = 2'b10;
  localparam int         ENT_W = AW + 34;

  typedef enum logic [1:0] {ST_IDLE, ST_WREQ, ST_RREQ, ST_RDATA} state_t;
  typedef struct packed {
    logic [AW-1:0] adr;
    logic [1:0]    wen;
    logic [31:0]   txd;
  } wr_ent_t;

  state_t         state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic           rd_busy_q, rd_busy_d;
  logic [AW-1:0]  rd_adr_q, rd_adr_d;
  logic [1:0]     rd_tag_q, rd_tag_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic           rwn_q, rwn_d;
  logic [1:0]     wen_q, wen_d;
  logic [31:0]    txd_q, txd_d;
  logic           wb_q, wb_d;
  logic           wb32_q, wb32_d;
  logic [31:0]    wb_data_q, wb_data_d;
  logic           err_q, err_d;
  logic [AW-1:0]  err_addr_q, err_addr_d;

  logic           tag_ok, acc, wr_acc, rd_acc, tmo;
  logic           q_full, q_empty, q_pop;
  logic [15:0]    d16;
  wr_ent_t        push_ent, head_ent;
  logic [ENT_W-1:0] head_raw;

  assign tag_ok   = (tag2 == TAG_W) | (tag2 == TAG_H) | (tag2 == TAG_L);
  assign stall    = q_full | rd_busy_q;
  assign acc      = issue & ~stall;
  assign wr_acc   = acc & ~rwn & tag_ok;
  assign rd_acc   = acc & rwn & tag_ok;
  assign tmo      = (cnt_q == TMO_W'(TMO_MAX));
  assign head_ent = wr_ent_t'(head_raw);

  always_comb begin
    d16          = sel ? data[31:16] : data[15:0];
    push_ent.adr = addr;
    push_ent.wen = 2'b11;
    push_ent.txd = data;
    case (tag2)
      TAG_H: begin
        push_ent.wen = 2'b10;
        push_ent.txd = {d16, 16'h0000};
      end
      TAG_L: begin
        push_ent.wen = 2'b01;
        push_ent.txd = {16'h0000, d16};
      end
      default: ;
    endcase
  end

  mp_sysbus_pq_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_wq (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .push_vld (wr_acc),
    .push_dat (push_ent),
    .pop_rdy  (q_pop),
    .head_dat (head_raw),
    .level    (q_level),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_busy_d  = rd_busy_q;
    rd_adr_d   = rd_adr_q;
    rd_tag_d   = rd_tag_q;
    adr_d      = adr_q;
    rwn_d      = rwn_q;
    wen_d      = wen_q;
    txd_d      = txd_q;
    wb_d       = 1'b0;
    wb32_d     = 1'b0;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    q_pop      = 1'b0;

    if (rd_acc) begin
      rd_busy_d = 1'b1;
      rd_adr_d  = addr;
      rd_tag_d  = tag2;
    end
    if (acc & ~tag_ok) begin
      err_d      = 1'b1;
      err_addr_d = addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          state_d = ST_WREQ;
          cnt_d   = '0;
          adr_d   = head_ent.adr;
          rwn_d   = 1'b0;
          wen_d   = head_ent.wen;
          txd_d   = head_ent.txd;
        end else if (rd_busy_q | rd_acc) begin
          // A read accepted this very cycle goes straight to the bus when nothing is queued.
          state_d = ST_RREQ;
          cnt_d   = '0;
          adr_d   = rd_acc ? addr : rd_adr_q;
          rwn_d   = 1'b1;
          wen_d   = 2'b00;
          txd_d   = '0;
        end
      end
      ST_WREQ: begin
        if (mgmt_ack) begin
          state_d = ST_IDLE;
        end else if (tmo) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_addr_d = adr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RREQ, ST_RDATA: begin
        if ((state_q == ST_RREQ) && mgmt_ack) begin
          state_d = ST_RDATA;
          cnt_d   = '0;
        end else if ((state_q == ST_RDATA) && mgmt_rxe) begin
          state_d   = ST_IDLE;
          rd_busy_d = 1'b0;
          wb_d      = 1'b1;
          wb32_d    = (rd_tag_q == TAG_W);
          wb_data_d = (rd_tag_q == TAG_H) ? {mgmt_rxd[31:16], mgmt_rxd[31:16]} : mgmt_rxd;
        end else if (tmo) begin
          state_d    = ST_IDLE;
          rd_busy_d  = 1'b0;
          wb_d       = 1'b1;
          wb32_d     = (rd_tag_q == TAG_W);
          wb_data_d  = 32'hFFFF_FFFF;
          err_d      = 1'b1;
          err_addr_d = adr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_busy_q  <= 1'b0;
      rd_adr_q   <= '0;
      rd_tag_q   <= '0;
      adr_q      <= '0;
      rwn_q      <= 1'b0;
      wen_q      <= '0;
      txd_q      <= '0;
      wb_q       <= 1'b0;
      wb32_q     <= 1'b0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_busy_q  <= rd_busy_d;
      rd_adr_q   <= rd_adr_d;
      rd_tag_q   <= rd_tag_d;
      adr_q      <= adr_d;
      rwn_q      <= rwn_d;
      wen_q      <= wen_d;
      txd_q      <= txd_d;
      wb_q       <= wb_d;
      wb32_q     <= wb32_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign mgmt_req = (state_q == ST_WREQ) | (state_q == ST_RREQ);
  assign mgmt_adr = 32'(adr_q);
  assign mgmt_rwn = rwn_q;
  assign mgmt_wen = wen_q;
  assign mgmt_txd = txd_q;
  assign wb       = wb_q;
  assign wb32     = wb32_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
endmodule

// File: tb/tb_mp_sysbus_pq.sv
// Bench for mp_sysbus_pq: vector table, multi-cycle corner sequences, and random traffic against a transaction model.
module tb_mp_sysbus_pq;
  localparam int AW      = 13;
  localparam int DEPTH   = 4;
  localparam int TMO_W   = 8;
  localparam int TMO_MAX = 255;
  localparam logic [1:0] TAG_W = 2'b00;
  localparam logic [1:0] TAG_H = 2'b01;
  localparam logic [1:0] TAG_L = 2'b10;
  localparam logic [1:0] TAG_X = 2'b11;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n, issue, rwn, sel;
  logic [1:0]    tag2;
  logic [AW-1:0] addr;
  logic [31:0]   data;
  logic          stall, wb, wb32, err, mgmt_req, mgmt_ack, mgmt_rwn, mgmt_rxe;
  logic [2:0]    q_level;
  logic [31:0]   wb_data, mgmt_adr, mgmt_txd, mgmt_rxd;
  logic [AW-1:0] err_addr;
  logic [1:0]    mgmt_wen;

  mp_sysbus_pq #(.AW(AW), .DEPTH(DEPTH), .TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .issue(issue), .rwn(rwn), .tag2(tag2), .sel(sel),
    .addr(addr), .data(data), .stall(stall), .q_level(q_level), .wb(wb), .wb32(wb32),
    .wb_data(wb_data), .err(err), .err_addr(err_addr), .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr),
    .mgmt_ack(mgmt_ack), .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen), .mgmt_txd(mgmt_txd),
    .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic          rwn;
    logic [1:0]    tag;
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   dat;
    logic          ill;
    logic [1:0]    wen;
    logic [31:0]   exp;
    logic          w32;
  } vec_t;
  vec_t vec[11];

  typedef struct {
    logic          rwn;
    logic [AW-1:0] adr;
    logic [1:0]    wen;
    logic [31:0]   txd;
  } bus_t;
  bus_t sb[$];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue = 1'b0; rwn = 1'b0; tag2 = TAG_W; sel = 1'b0; addr = '0; data = '0;
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic drive(input logic r, input logic [1:0] t, input logic s, input logic [AW-1:0] a,
                       input logic [31:0] d);
    issue = 1'b1; rwn = r; tag2 = t; sel = s; addr = a; data = d;
  endtask

  function automatic logic [1:0] wen_of(input logic [1:0] t);
    case (t)
      TAG_W:   return 2'b11;
      TAG_H:   return 2'b10;
      TAG_L:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] txd_of(input logic [1:0] t, input logic s, input logic [31:0] d);
    logic [15:0] h;
    h = s ? d[31:16] : d[15:0];
    case (t)
      TAG_H:   return {h, 16'h0000};
      TAG_L:   return {16'h0000, h};
      default: return d;
    endcase
  endfunction

  int          k, got, maxlvl;
  logic        acc_now, rd_out, exp_wb, exp_wb32, exp_err, wait_rxe, drain;
  logic [31:0] exp_wb_data, rxv;
  logic [1:0]  rd_tag_m;
  logic [AW-1:0] exp_err_addr;
  logic [31:0] t3_adr[3];
  logic [31:0] t3_rwn[3];
  logic [31:0] t3_txd[3];
  bus_t        e;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{1'b0, TAG_W, 1'b0, 13'h0010, 32'hDEAD_BEEF, 1'b0, 2'b11, 32'hDEAD_BEEF, 1'b0};
    vec[1]  = '{1'b0, TAG_H, 1'b1, 13'h0011, 32'hAABB_CCDD, 1'b0, 2'b10, 32'hAABB_0000, 1'b0};
    vec[2]  = '{1'b0, TAG_H, 1'b0, 13'h0012, 32'hAABB_CCDD, 1'b0, 2'b10, 32'hCCDD_0000, 1'b0};
    vec[3]  = '{1'b0, TAG_L, 1'b1, 13'h0013, 32'hAABB_CCDD, 1'b0, 2'b01, 32'h0000_AABB, 1'b0};
    vec[4]  = '{1'b0, TAG_L, 1'b0, 13'h0014, 32'h1234_5678, 1'b0, 2'b01, 32'h0000_5678, 1'b0};
    vec[5]  = '{1'b1, TAG_W, 1'b0, 13'h1FFF, 32'hCAFE_F00D, 1'b0, 2'b00, 32'hCAFE_F00D, 1'b1};
    vec[6]  = '{1'b1, TAG_H, 1'b0, 13'h0020, 32'h1234_5678, 1'b0, 2'b00, 32'h1234_1234, 1'b0};
    vec[7]  = '{1'b1, TAG_L, 1'b1, 13'h0021, 32'h89AB_CDEF, 1'b0, 2'b00, 32'h89AB_CDEF, 1'b0};
    vec[8]  = '{1'b0, TAG_X, 1'b0, 13'h1ABC, 32'h5555_AAAA, 1'b1, 2'b00, 32'h0000_0000, 1'b0};
    vec[9]  = '{1'b1, TAG_X, 1'b0, 13'h0FFF, 32'h0000_0000, 1'b1, 2'b00, 32'h0000_0000, 1'b0};
    vec[10] = '{1'b0, TAG_H, 1'b1, 13'h0000, 32'hFFFF_0000, 1'b0, 2'b10, 32'hFFFF_0000, 1'b0};

    do_reset();
    tick();
    chk("rst_stall", stall, 0);   chk("rst_qlvl", q_level, 0);  chk("rst_wb", wb, 0);
    chk("rst_wb32", wb32, 0);     chk("rst_wbdat", wb_data, 0); chk("rst_err", err, 0);
    chk("rst_erraddr", err_addr, 0); chk("rst_req", mgmt_req, 0); chk("rst_adr", mgmt_adr, 0);
    chk("rst_rwn", mgmt_rwn, 0);  chk("rst_wen", mgmt_wen, 0);  chk("rst_txd", mgmt_txd, 0);

    // Vector table: one isolated transaction per entry.
    foreach (vec[i]) begin
      drive(vec[i].rwn, vec[i].tag, vec[i].sel, vec[i].addr, vec[i].dat);
      tick();
      issue = 1'b0;
      if (vec[i].ill) begin
        chk("ill_err", err, 1); chk("ill_erraddr", err_addr, 32'(vec[i].addr));
        chk("ill_qlvl", q_level, 0); chk("ill_req", mgmt_req, 0); chk("ill_stall", stall, 0);
        tick();
        chk("ill_err_pulse", err, 0);
      end else if (!vec[i].rwn) begin
        chk("wr_n1_req", mgmt_req, 0); chk("wr_n1_qlvl", q_level, 1);
        tick();
        chk("wr_n2_req", mgmt_req, 1); chk("wr_wen", mgmt_wen, 32'(vec[i].wen));
        chk("wr_txd", mgmt_txd, vec[i].exp); chk("wr_adr", mgmt_adr, 32'(vec[i].addr));
        chk("wr_rwn", mgmt_rwn, 0); chk("wr_n2_qlvl", q_level, 0);
        mgmt_ack = 1'b1; tick(); mgmt_ack = 1'b0;
        chk("wr_done_req", mgmt_req, 0); chk("wr_no_wb", wb, 0);
      end else begin
        chk("rd_n1_req", mgmt_req, 1); chk("rd_rwn", mgmt_rwn, 1);
        chk("rd_adr", mgmt_adr, 32'(vec[i].addr)); chk("rd_wen", mgmt_wen, 0); chk("rd_stall", stall, 1);
        mgmt_ack = 1'b1; tick(); mgmt_ack = 1'b0;
        chk("rd_data_req", mgmt_req, 0); chk("rd_data_stall", stall, 1);
        mgmt_rxe = 1'b1; mgmt_rxd = vec[i].dat; tick(); mgmt_rxe = 1'b0;
        chk("rd_wb", wb, 1); chk("rd_wbdat", wb_data, vec[i].exp);
        chk("rd_wb32", wb32, 32'(vec[i].w32)); chk("rd_wb_stall", stall, 0);
        tick();
        chk("rd_wb_pulse", wb, 0);
      end
    end

    // Queue fill with the bus stalled: the head moves to the bus, then DEPTH more fill the queue.
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("fill_stall_free", stall, 0);
      drive(1'b0, TAG_W, 1'b0, 13'(13'h100 + i), 32'hC0DE_0000 | 32'(i));
      tick();
    end
    chk("fill_qlvl", q_level, DEPTH); chk("fill_stall", stall, 1);
    chk("fill_req", mgmt_req, 1);      chk("fill_head", mgmt_adr, 32'h100);
    drive(1'b0, TAG_W, 1'b0, 13'h105, 32'hC0DE_0005);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fill_held_qlvl", q_level, DEPTH);
    end
    got = 0; maxlvl = 0;
    for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
      acc_now = issue & ~stall;
      mgmt_ack = mgmt_req;
      if (mgmt_req) begin
        chk("fill_order_adr", mgmt_adr, 32'h100 + 32'(got));
        chk("fill_order_txd", mgmt_txd, 32'hC0DE_0000 | 32'(got));
        got++;
      end
      tick();
      if (acc_now) issue = 1'b0;
      if (int'(q_level) > maxlvl) maxlvl = int'(q_level);
    end
    mgmt_ack = 1'b0; issue = 1'b0;
    chk("fill_all_drained", got, 6); chk("fill_maxlvl", maxlvl, DEPTH); chk("fill_end_qlvl", q_level, 0);

    // Two posted writes then a halfword read: the read waits for both write acks.
    t3_adr[0] = 32'h030; t3_rwn[0] = 0; t3_txd[0] = 32'h1111_2222;
    t3_adr[1] = 32'h031; t3_rwn[1] = 0; t3_txd[1] = 32'h0000_4444;
    t3_adr[2] = 32'h020; t3_rwn[2] = 1; t3_txd[2] = 32'h0;
    drive(1'b0, TAG_W, 1'b0, 13'h030, 32'h1111_2222); tick();
    drive(1'b0, TAG_L, 1'b0, 13'h031, 32'h3333_4444); tick();
    chk("seq_rd_accept_stall", stall, 0);
    drive(1'b1, TAG_H, 1'b0, 13'h020, 32'h0); tick(); issue = 1'b0;
    chk("seq_rd_blocks", stall, 1);
    got = 0;
    for (int cyc = 0; cyc < 50 && got < 3; cyc++) begin
      mgmt_ack = mgmt_req;
      if (mgmt_req) begin
        chk("seq_adr", mgmt_adr, t3_adr[got]); chk("seq_rwn", mgmt_rwn, t3_rwn[got]);
        if (t3_rwn[got] == 0) chk("seq_txd", mgmt_txd, t3_txd[got]);
        got++;
      end
      tick();
    end
    mgmt_ack = 1'b0;
    chk("seq_count", got, 3);
    mgmt_rxe = 1'b1; mgmt_rxd = 32'h1234_5678; tick(); mgmt_rxe = 1'b0;
    chk("seq_wb", wb, 1); chk("seq_wbdat", wb_data, 32'h1234_1234); chk("seq_wb32", wb32, 0);

    // Read whose data never returns.
    tick();
    drive(1'b1, TAG_W, 1'b0, 13'h1F0, 32'h0); tick(); issue = 1'b0;
    mgmt_ack = 1'b1; tick(); mgmt_ack = 1'b0;
    k = 0;
    while (!wb && k < 600) begin tick(); k++; end
    chk("rdtmo_latency", k, TMO_MAX + 1);
    chk("rdtmo_wbdat", wb_data, 32'hFFFF_FFFF); chk("rdtmo_wb32", wb32, 1);
    chk("rdtmo_err", err, 1); chk("rdtmo_erraddr", err_addr, 32'h1F0);
    chk("rdtmo_stall", stall, 0); chk("rdtmo_req", mgmt_req, 0);

    // Write acked in the last allowed cycle completes cleanly.
    tick();
    drive(1'b0, TAG_W, 1'b0, 13'h0AB, 32'h0BAD_F00D); tick(); issue = 1'b0;
    tick();
    repeat (TMO_MAX) tick();
    chk("wrlast_req", mgmt_req, 1);
    mgmt_ack = 1'b1; tick(); mgmt_ack = 1'b0;
    chk("wrlast_err", err, 0); chk("wrlast_req_done", mgmt_req, 0);
    tick();
    chk("wrlast_err_after", err, 0);

    // Write never acked is dropped with an error.
    drive(1'b0, TAG_W, 1'b0, 13'h0CD, 32'h0); tick(); issue = 1'b0;
    tick();
    repeat (TMO_MAX) tick();
    chk("wrtmo_req_still", mgmt_req, 1);
    tick();
    chk("wrtmo_err", err, 1); chk("wrtmo_erraddr", err_addr, 32'h0CD);
    chk("wrtmo_req", mgmt_req, 0); chk("wrtmo_nowb", wb, 0); chk("wrtmo_qlvl", q_level, 0);

    // Reset with queued writes and one in flight.
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, TAG_W, 1'b0, 13'(13'h200 + i), 32'(i)); tick();
    end
    issue = 1'b0;
    chk("rst3_pre_qlvl", q_level, 3); chk("rst3_pre_req", mgmt_req, 1);
    do_reset();
    chk("rst3_req", mgmt_req, 0); chk("rst3_qlvl", q_level, 0); chk("rst3_stall", stall, 0);
    mgmt_ack = 1'b1; tick(); tick(); mgmt_ack = 1'b0;
    chk("rst3_late_ack_req", mgmt_req, 0);

    // Reset during a read request; late ack and rxe are ignored.
    drive(1'b1, TAG_W, 1'b0, 13'h210, 32'h0); tick(); issue = 1'b0;
    chk("rstrd_pre_req", mgmt_req, 1);
    do_reset();
    chk("rstrd_req", mgmt_req, 0); chk("rstrd_stall", stall, 0);
    mgmt_ack = 1'b1; tick(); mgmt_ack = 1'b0;
    mgmt_rxe = 1'b1; mgmt_rxd = 32'h7777_7777; tick(); mgmt_rxe = 1'b0;
    chk("rstrd_nowb", wb, 0);
    tick();
    chk("rstrd_nowb2", wb, 0); chk("rstrd_req2", mgmt_req, 0);

    // Random traffic against a transaction-level model.
    do_reset();
    rd_out = 0; exp_wb = 0; exp_err = 0; wait_rxe = 0; exp_wb_data = '0; exp_wb32 = 0;
    rd_tag_m = TAG_W; exp_err_addr = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      drain = (cyc >= 3000);
      if (drain && sb.size() == 0 && !rd_out && !exp_wb && !exp_err && !wait_rxe) break;
      if (exp_wb) begin
        chk("rnd_wb", wb, 1); chk("rnd_wbdat", wb_data, exp_wb_data); chk("rnd_wb32", wb32, 32'(exp_wb32));
        exp_wb = 0; rd_out = 0;
      end else if (wb) chk("rnd_wb_spurious", wb, 0);
      if (exp_err) begin
        chk("rnd_err", err, 1); chk("rnd_erraddr", err_addr, 32'(exp_err_addr));
        exp_err = 0;
      end else if (err) chk("rnd_err_spurious", err, 0);
      if (rd_out) chk("rnd_stall_rd", stall, 1);
      if (int'(q_level) > DEPTH) chk("rnd_qlvl", q_level, DEPTH);

      mgmt_ack = 1'b0; mgmt_rxe = 1'b0;
      if (wait_rxe) begin
        if ($urandom_range(0, 2) == 0) begin
          rxv = $urandom;
          mgmt_rxe = 1'b1; mgmt_rxd = rxv;
          exp_wb = 1; exp_wb32 = (rd_tag_m == TAG_W);
          exp_wb_data = (rd_tag_m == TAG_H) ? {rxv[31:16], rxv[31:16]} : rxv;
          wait_rxe = 0;
        end
      end else if (mgmt_req && $urandom_range(0, 2) == 0) begin
        mgmt_ack = 1'b1;
        if (sb.size() == 0) chk("rnd_bus_unexpected", mgmt_req, 0);
        else begin
          e = sb.pop_front();
          chk("rnd_bus_rwn", mgmt_rwn, 32'(e.rwn)); chk("rnd_bus_adr", mgmt_adr, 32'(e.adr));
          if (!e.rwn) begin
            chk("rnd_bus_wen", mgmt_wen, 32'(e.wen)); chk("rnd_bus_txd", mgmt_txd, e.txd);
          end else wait_rxe = 1;
        end
      end

      issue = 1'b0;
      if (!drain && $urandom_range(0, 1) == 1) begin
        drive(1'($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0) ? TAG_X : 2'($urandom_range(0, 2)),
              1'($urandom), 13'($urandom), $urandom);
        if (!stall) begin
          if (tag2 == TAG_X) begin
            exp_err = 1; exp_err_addr = addr;
          end else if (rwn) begin
            sb.push_back('{1'b1, addr, 2'b00, 32'h0});
            rd_out = 1; rd_tag_m = tag2;
          end else begin
            sb.push_back('{1'b0, addr, wen_of(tag2), txd_of(tag2, sel, data)});
          end
        end
      end
      tick();
    end
    idle_inputs();
    chk("rnd_sb_empty", sb.size(), 0); chk("rnd_rd_done", rd_out, 0); chk("rnd_end_qlvl", q_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
